// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller between program_memory and decode
//
// Owns the program counter, drives the program_memory address, waits out the
// read latency and hands each fetched word to decode over a valid/ready
// handshake. Handles jump redirects and, optionally, stops on HALT.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   : an accepted word with instr[15:12] == HALT_OPCODE enters HALT
//   undefined : no opcode decode, HALT unreachable, o_halted tied to 0
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-low reset
//   i_start, i_start_addr  begin fetching at i_start_addr (IDLE/HALT only)
//   i_redirect,
//   i_redirect_addr        taken jump target (WAIT/HOLD only)
//   o_mem_addr             registered address to program_memory
//   i_mem_data             program_memory read data
//   o_instr, o_instr_pc    captured word and the address it came from
//   o_instr_valid,
//   i_instr_ready          handshake to decode
//   o_busy, o_halted       status: WAIT/HOLD, HALT

module fetch_sequencer #(
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 16,
  parameter int         MEM_LAT     = 1,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic              o_busy,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  state_t            r_state;
  logic [1:0]        r_lat_cnt;
  logic [ADDR_W-1:0] r_mem_addr;   // doubles as the PC: they are always equal
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;

  state_t            w_state_nxt;
  logic [1:0]        w_lat_cnt_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_instr_nxt;
  logic [ADDR_W-1:0] w_instr_pc_nxt;
  logic              w_instr_valid_nxt;
  logic              w_is_halt;

  // Opcode compare is gated by HALT_EN so the default build never enters HALT.
  assign w_is_halt = HALT_EN && (r_instr[DATA_W-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_lat_cnt     <= 2'd0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lat_cnt     <= w_lat_cnt_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_lat_cnt_nxt     = r_lat_cnt;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          w_mem_addr_nxt = i_start_addr;
          w_lat_cnt_nxt  = 2'd0;
          w_state_nxt    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_redirect) begin
          // Restart the latency count: the read in flight is for the old PC.
          w_mem_addr_nxt = i_redirect_addr;
          w_lat_cnt_nxt  = 2'd0;
        end else if (r_lat_cnt == LAT) begin
          w_instr_nxt       = i_mem_data;
          w_instr_pc_nxt    = r_mem_addr;
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = S_HOLD;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 2'd1;
        end
      end

      S_HOLD: begin
        if (i_redirect) begin
          // Redirect wins over a same-edge accept and over HALT entry.
          w_mem_addr_nxt    = i_redirect_addr;
          w_instr_valid_nxt = 1'b0;
          w_lat_cnt_nxt     = 2'd0;
          w_state_nxt       = S_WAIT;
        end else if (r_instr_valid && i_instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          if (w_is_halt) begin
            w_state_nxt = S_HALT;
          end else begin
            w_mem_addr_nxt = r_mem_addr + 1'b1;
            w_lat_cnt_nxt  = 2'd0;
            w_state_nxt    = S_WAIT;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_busy        = (r_state == S_WAIT) || (r_state == S_HOLD);
  assign o_halted      = HALT_EN && (r_state == S_HALT);

endmodule
